// File: rtl/gpio_scan_sram_ctrl.sv
// GPIO scan-chain controller that launches single SRAM accesses and captures read data for scan-out.
// Build macro SCAN_PARITY_EN appends an even-parity LSB to the chain and suppresses accesses with bad parity.
module gpio_scan_sram_ctrl #(
    parameter int SEL_WIDTH    = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scan_en,
    input  logic                   scan_in,
    output logic                   scan_out,
    input  logic                   sram_load,
    input  logic                   global_csb,
    output logic                   busy,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   csb0,
    output logic                   web0,
    output logic                   csb1,
    output logic                   web1,
    output logic [ADDR_WIDTH-1:0]  addr0,
    output logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  din1,
    output logic [WMASK_WIDTH-1:0] wmask0,
    output logic [WMASK_WIDTH-1:0] wmask1,
    input  logic [DATA_WIDTH-1:0]  dout0,
    input  logic [DATA_WIDTH-1:0]  dout1,
    output logic                   parity_err
);

    localparam int PW = ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH;
    localparam int L  = SEL_WIDTH + 2 * PW;
`ifdef SCAN_PARITY_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    localparam int CL = L + OFF;

    // Bit offsets of each field; port 1 sits just above the optional parity bit.
    localparam int WM1 = OFF;
    localparam int WE1 = WM1 + WMASK_WIDTH;
    localparam int CS1 = WE1 + 1;
    localparam int DI1 = CS1 + 1;
    localparam int AD1 = DI1 + DATA_WIDTH;
    localparam int WM0 = OFF + PW;
    localparam int WE0 = WM0 + WMASK_WIDTH;
    localparam int CS0 = WE0 + 1;
    localparam int DI0 = CS0 + 1;
    localparam int AD0 = DI0 + DATA_WIDTH;
    localparam int SL  = OFF + 2 * PW;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_CAPTURE} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [CL-1:0]         chain_q, chain_d;
    logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
    logic                  csb0_q, csb0_d, csb1_q, csb1_d;
    logic                  gcsb_prev_q, gcsb_prev_d;
    logic                  trig;
    logic                  par_ok;
`ifdef SCAN_PARITY_EN
    logic                  perr_q, perr_d;
    assign par_ok     = ~(^chain_q);
    assign parity_err = perr_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign trig = gcsb_prev_q & ~global_csb;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chain_d     = chain_q;
        dout0_d     = dout0_q;
        dout1_d     = dout1_q;
        csb0_d      = 1'b1;
        csb1_d      = 1'b1;
        gcsb_prev_d = global_csb;
`ifdef SCAN_PARITY_EN
        perr_d      = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A trigger that coincides with scan_en is consumed here and never replayed.
                if (scan_en) begin
                    chain_d = {chain_q[CL-2:0], scan_in};
                end else if (trig) begin
                    if (par_ok) begin
                        state_d = S_ACCESS;
                        csb0_d  = chain_q[CS0];
                        csb1_d  = chain_q[CS1];
                    end
`ifdef SCAN_PARITY_EN
                    perr_d = ~par_ok;
`endif
                end else if (sram_load) begin
                    chain_d[DI0 +: DATA_WIDTH] = dout0_q;
                    chain_d[DI1 +: DATA_WIDTH] = dout1_q;
`ifdef SCAN_PARITY_EN
                    chain_d[0] = ^chain_d[CL-1:1];
`endif
                end
            end
            S_ACCESS: begin
                if (READ_LATENCY > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = 3'd1;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'(READ_LATENCY - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_CAPTURE: begin
                // Only ports that actually performed a read refresh their held data.
                if (!chain_q[CS0] && chain_q[WE0]) dout0_d = dout0;
                if (!chain_q[CS1] && chain_q[WE1]) dout1_d = dout1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            chain_q     <= '1;
            dout0_q     <= '0;
            dout1_q     <= '0;
            csb0_q      <= 1'b1;
            csb1_q      <= 1'b1;
            gcsb_prev_q <= 1'b1;
`ifdef SCAN_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chain_q     <= chain_d;
            dout0_q     <= dout0_d;
            dout1_q     <= dout1_d;
            csb0_q      <= csb0_d;
            csb1_q      <= csb1_d;
            gcsb_prev_q <= gcsb_prev_d;
`ifdef SCAN_PARITY_EN
            perr_q      <= perr_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign scan_out = chain_q[CL-1];
    assign csb0     = csb0_q;
    assign csb1     = csb1_q;
    assign sel      = chain_q[SL  +: SEL_WIDTH];
    assign addr0    = chain_q[AD0 +: ADDR_WIDTH];
    assign din0     = chain_q[DI0 +: DATA_WIDTH];
    assign web0     = chain_q[WE0];
    assign wmask0   = chain_q[WM0 +: WMASK_WIDTH];
    assign addr1    = chain_q[AD1 +: ADDR_WIDTH];
    assign din1     = chain_q[DI1 +: DATA_WIDTH];
    assign web1     = chain_q[WE1];
    assign wmask1   = chain_q[WM1 +: WMASK_WIDTH];

endmodule

// File: tb/tb_gpio_scan_sram_ctrl.sv
// Bench for gpio_scan_sram_ctrl: a READ_LATENCY=1 instance backed by an SRAM model and a
// READ_LATENCY=3 instance fed with per-cycle tagged read data, sharing all scan/control inputs.
module tb_gpio_scan_sram_ctrl;
    localparam int SW = 4, AW = 16, DW = 32, MW = 4;
    localparam int PW = AW + DW + 2 + MW;
    localparam int L  = SW + 2 * PW;
`ifdef SCAN_PARITY_EN
    localparam int CL = L + 1;
`else
    localparam int CL = L;
`endif
    typedef logic [CL-1:0] chain_t;

    logic clk = 1'b0;
    logic reset = 1'b1, scan_en = 1'b0, scan_in = 1'b0, sram_load = 1'b0, global_csb = 1'b1;

    logic so1, busy1, csb0_1, web0_1, csb1_1, web1_1, perr1;
    logic [SW-1:0] sel1;
    logic [AW-1:0] a0_1, a1_1;
    logic [DW-1:0] di0_1, di1_1, do0_1, do1_1;
    logic [MW-1:0] m0_1, m1_1;

    logic so3, busy3, csb0_3, web0_3, csb1_3, web1_3, perr3;
    logic [SW-1:0] sel3;
    logic [AW-1:0] a0_3, a1_3;
    logic [DW-1:0] di0_3, di1_3, do0_3, do1_3;
    logic [MW-1:0] m0_3, m1_3;

    int vec = 0, errs = 0, lo_cnt = 0;
    chain_t exp1_q[$], exp3_q[$];
    logic [DW-1:0] mem [16];

    always #5 clk = ~clk;

    gpio_scan_sram_ctrl #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so1),
        .sram_load(sram_load), .global_csb(global_csb), .busy(busy1), .sel(sel1),
        .csb0(csb0_1), .web0(web0_1), .csb1(csb1_1), .web1(web1_1),
        .addr0(a0_1), .addr1(a1_1), .din0(di0_1), .din1(di1_1),
        .wmask0(m0_1), .wmask1(m1_1), .dout0(do0_1), .dout1(do1_1), .parity_err(perr1));

    gpio_scan_sram_ctrl #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so3),
        .sram_load(sram_load), .global_csb(global_csb), .busy(busy3), .sel(sel3),
        .csb0(csb0_3), .web0(web0_3), .csb1(csb1_3), .web1(web1_3),
        .addr0(a0_3), .addr1(a1_3), .din0(di0_3), .din1(di1_3),
        .wmask0(m0_3), .wmask1(m1_3), .dout0(do0_3), .dout1(do1_3), .parity_err(perr3));

    // Synchronous SRAM model for the latency-1 instance: byte-masked write, registered read.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        do0_1 = '0; do1_1 = '0; do0_3 = '0; do1_3 = '0;
    end
    always @(posedge clk) begin
        if (!csb0_1) begin
            if (!web0_1) begin
                for (int b = 0; b < MW; b++) if (m0_1[b]) mem[a0_1[3:0]][8*b +: 8] <= di0_1[8*b +: 8];
            end else do0_1 <= mem[a0_1[3:0]];
        end
        if (!csb1_1) begin
            if (!web1_1) begin
                for (int b = 0; b < MW; b++) if (m1_1[b]) mem[a1_1[3:0]][8*b +: 8] <= di1_1[8*b +: 8];
            end else do1_1 <= mem[a1_1[3:0]];
        end
    end

    always @(negedge clk) if (!csb0_1 || !csb1_1 || !csb0_3 || !csb1_3) lo_cnt <= lo_cnt + 1;

    function automatic chain_t mk(input logic [SW-1:0] s,
                                  input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                  input logic c0, input logic w0, input logic [MW-1:0] m0,
                                  input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                  input logic c1, input logic w1, input logic [MW-1:0] m1);
        logic [L-1:0] b;
        b = {s, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
`ifdef SCAN_PARITY_EN
        return {b, ^b};
`else
        return b;
`endif
    endfunction

    // Shift v in MSB first; optionally drop global_csb while shifting bit trig_at.
    task automatic scan_chain(input chain_t v, input int trig_at);
        for (int i = CL - 1; i >= 0; i--) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = v[i];
            if (i == trig_at) global_csb = 1'b0;
        end
        @(negedge clk);
        scan_en = 1'b0;
        @(negedge clk);
        global_csb = 1'b1;
    endtask

    // Scan out both chains (dut1 bits fed back into scan_in) and compare with the scoreboard.
    task automatic scan_check(input string nm);
        chain_t g1, g3, e1, e3;
        for (int i = CL - 1; i >= 0; i--) begin
            @(negedge clk);
            g1[i] = so1;
            g3[i] = so3;
            scan_en = 1'b1;
            scan_in = so1;
        end
        @(negedge clk);
        scan_en = 1'b0;
        e1 = exp1_q.pop_front();
        e3 = exp3_q.pop_front();
        vec++; if (g1 !== e1) begin errs++; $display("FAIL %s_lat1: got %h want %h", nm, g1, e1); end
        vec++; if (g3 !== e3) begin errs++; $display("FAIL %s_lat3: got %h want %h", nm, g3, e3); end
    endtask

    // Pulse global_csb low and watch 10 cycles; busy_abuse also drives scan_en/sram_load
    // and a second falling edge while both instances are busy.
    task automatic fire(input bit busy_abuse, output int c0, output int c1, output int b1,
                        output int c03, output int b3, output logic [AW-1:0] ad, output logic we);
        c0 = 0; c1 = 0; b1 = 0; c03 = 0; b3 = 0; ad = '0; we = 1'b1;
        @(negedge clk);
        global_csb = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            do0_3 = 32'hA000_0000 + k;
            do1_3 = 32'hB000_0000 + k;
            if (!csb0_1) begin c0++; ad = a0_1; we = web0_1; end
            if (!csb1_1) c1++;
            if (busy1) b1++;
            if (!csb0_3) c03++;
            if (busy3) b3++;
            if (k == 1) global_csb = 1'b1;
            if (busy_abuse && k == 1) begin scan_en = 1'b1; sram_load = 1'b1; scan_in = 1'b0; end
            if (busy_abuse && k == 2) begin scan_en = 1'b0; sram_load = 1'b0; global_csb = 1'b0; end
        end
        global_csb = 1'b1;
    endtask

    task automatic pulse_load();
        @(negedge clk); sram_load = 1'b1;
        @(negedge clk); sram_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        vec++; if ({so1, so3} !== 2'b11) begin errs++; $display("FAIL rst_scan_out: got %b want 11", {so1, so3}); end
        vec++; if ({csb0_1, csb1_1, csb0_3, csb1_3} !== 4'hF) begin errs++; $display("FAIL rst_csb: got %b want 1111", {csb0_1, csb1_1, csb0_3, csb1_3}); end
        vec++; if ({busy1, busy3} !== 2'b00) begin errs++; $display("FAIL rst_busy: got %b want 00", {busy1, busy3}); end
        vec++; if ({sel1, sel3} !== 8'hFF) begin errs++; $display("FAIL rst_sel: got %h want ff", {sel1, sel3}); end
        vec++; if ({perr1, perr3} !== 2'b00) begin errs++; $display("FAIL rst_parity_err: got %b want 00", {perr1, perr3}); end
        exp1_q.push_back('1); exp3_q.push_back('1);
        scan_check("rst_chain");
    endtask

    task automatic test_write();
        int c0, c1, b1, c03, b3; logic [AW-1:0] ad; logic we; chain_t w;
        w = mk(4'h3, 16'h1, 32'h3, 1'b0, 1'b0, 4'hF, 16'h0, 32'h0, 1'b1, 1'b1, 4'hF);
        scan_chain(w, -1);
        vec++; if ({sel1, a0_1, di0_1, web0_1, m0_1} !== {4'h3, 16'h1, 32'h3, 1'b0, 4'hF})
            begin errs++; $display("FAIL wr_fields: got %h want %h", {sel1, a0_1, di0_1, web0_1, m0_1}, {4'h3, 16'h1, 32'h3, 1'b0, 4'hF}); end
        fire(1'b0, c0, c1, b1, c03, b3, ad, we);
        vec++; if (c0 !== 1) begin errs++; $display("FAIL wr_csb0_cycles: got %0d want 1", c0); end
        vec++; if (c1 !== 0) begin errs++; $display("FAIL wr_csb1_cycles: got %0d want 0", c1); end
        vec++; if ({ad, we} !== {16'h1, 1'b0}) begin errs++; $display("FAIL wr_addr_web: got %h want %h", {ad, we}, {16'h1, 1'b0}); end
        vec++; if (b1 !== 2) begin errs++; $display("FAIL wr_busy_lat1: got %0d want 2", b1); end
        vec++; if (b3 !== 4) begin errs++; $display("FAIL wr_busy_lat3: got %0d want 4", b3); end
        vec++; if (c03 !== 1) begin errs++; $display("FAIL wr_csb0_lat3: got %0d want 1", c03); end
        // Port-1-only write of addr 2
        w = mk(4'h3, 16'h0, 32'h0, 1'b1, 1'b1, 4'hF, 16'h2, 32'h18, 1'b0, 1'b0, 4'hF);
        scan_chain(w, -1);
        vec++; if ({sel3, a1_3, di1_3, web1_3, m1_3} !== {4'h3, 16'h2, 32'h18, 1'b0, 4'hF})
            begin errs++; $display("FAIL wr1_fields: got %h want %h", {sel3, a1_3, di1_3, web1_3, m1_3}, {4'h3, 16'h2, 32'h18, 1'b0, 4'hF}); end
        fire(1'b0, c0, c1, b1, c03, b3, ad, we);
        vec++; if ({c0, c1} !== {32'd0, 32'd1}) begin errs++; $display("FAIL wr1_csb_cycles: got %0d/%0d want 0/1", c0, c1); end
        // Writes never refresh captured data, so a load brings in the reset zeros.
        pulse_load();
        w = mk(4'h3, 16'h0, 32'h0, 1'b1, 1'b1, 4'hF, 16'h2, 32'h0, 1'b0, 1'b0, 4'hF);
        exp1_q.push_back(w); exp3_q.push_back(w);
        scan_check("wr_no_capture");
    endtask

    task automatic test_read();
        int c0, c1, b1, c03, b3; logic [AW-1:0] ad; logic we; chain_t r;
        r = mk(4'h3, 16'h1, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 16'h2, 32'h1234_5678, 1'b0, 1'b1, 4'hF);
        scan_chain(r, -1);
        fire(1'b0, c0, c1, b1, c03, b3, ad, we);
        vec++; if ({c0, c1} !== {32'd1, 32'd1}) begin errs++; $display("FAIL rd_csb_cycles: got %0d/%0d want 1/1", c0, c1); end
        vec++; if (b3 !== 4) begin errs++; $display("FAIL rd_busy_lat3: got %0d want 4", b3); end
        pulse_load();
        exp1_q.push_back(mk(4'h3, 16'h1, 32'h3, 1'b0, 1'b1, 4'hF, 16'h2, 32'h18, 1'b0, 1'b1, 4'hF));
        exp3_q.push_back(mk(4'h3, 16'h1, 32'hA000_0004, 1'b0, 1'b1, 4'hF, 16'h2, 32'hB000_0004, 1'b0, 1'b1, 4'hF));
        scan_check("rd_load");
    endtask

    task automatic test_trigger_during_scan();
        chain_t x; int lo0;
        x = mk(4'h5, 16'h7, 32'h55, 1'b0, 1'b0, 4'hF, 16'h8, 32'h66, 1'b0, 1'b0, 4'hF);
        lo0 = lo_cnt;
        scan_chain(x, CL - 5);
        repeat (5) @(negedge clk);
        vec++; if (lo_cnt !== lo0) begin errs++; $display("FAIL scan_trig_csb: got %0d want 0 low cycles", lo_cnt - lo0); end
        vec++; if ({busy1, busy3} !== 2'b00) begin errs++; $display("FAIL scan_trig_busy: got %b want 00", {busy1, busy3}); end
        exp1_q.push_back(x); exp3_q.push_back(x);
        scan_check("scan_trig_chain");
    endtask

    task automatic test_back_to_back();
        int c0, c1, b1, c03, b3; logic [AW-1:0] ad; logic we; chain_t x;
        x = mk(4'h5, 16'h7, 32'h55, 1'b0, 1'b0, 4'hF, 16'h8, 32'h66, 1'b0, 1'b0, 4'hF);
        scan_chain(x, -1);
        fire(1'b1, c0, c1, b1, c03, b3, ad, we);
        vec++; if ({c0, c1, c03} !== {32'd1, 32'd1, 32'd1}) begin errs++; $display("FAIL busy_retrig_csb: got %0d/%0d/%0d want 1/1/1", c0, c1, c03); end
        vec++; if ({b1, b3} !== {32'd2, 32'd4}) begin errs++; $display("FAIL busy_retrig_busy: got %0d/%0d want 2/4", b1, b3); end
        exp1_q.push_back(x); exp3_q.push_back(x);
        scan_check("busy_frozen");
    endtask

    task automatic test_parity();
        int c0, c1, b1, c03, b3; logic [AW-1:0] ad; logic we; chain_t g;
        g = mk(4'h1, 16'h5, 32'h77, 1'b0, 1'b0, 4'hF, 16'h0, 32'h0, 1'b1, 1'b1, 4'hF);
`ifdef SCAN_PARITY_EN
        scan_chain(g ^ chain_t'(1), -1);
        fire(1'b0, c0, c1, b1, c03, b3, ad, we);
        vec++; if ({c0, b1} !== {32'd0, 32'd0}) begin errs++; $display("FAIL par_bad_access: got %0d/%0d want 0/0", c0, b1); end
        vec++; if ({perr1, perr3} !== 2'b11) begin errs++; $display("FAIL par_bad_err: got %b want 11", {perr1, perr3}); end
`endif
        scan_chain(g, -1);
        fire(1'b0, c0, c1, b1, c03, b3, ad, we);
        vec++; if ({c0, ad} !== {32'd1, 16'h5}) begin errs++; $display("FAIL par_good_access: got %0d/%h want 1/0005", c0, ad); end
        vec++; if ({perr1, perr3} !== 2'b00) begin errs++; $display("FAIL par_good_err: got %b want 00", {perr1, perr3}); end
    endtask

    task automatic test_reset_mid_access();
        scan_chain(mk(4'h3, 16'h1, 32'h0, 1'b0, 1'b1, 4'hF, 16'h2, 32'h0, 1'b0, 1'b1, 4'hF), -1);
        @(negedge clk); global_csb = 1'b0;
        @(negedge clk);
        vec++; if ({csb0_1, csb0_3, busy1, busy3} !== 4'b0011) begin errs++; $display("FAIL mid_access: got %b want 0011", {csb0_1, csb0_3, busy1, busy3}); end
        reset = 1'b1; global_csb = 1'b1;
        @(negedge clk);
        vec++; if ({csb0_1, csb1_1, csb0_3, csb1_3, busy1, busy3} !== 6'b111100) begin errs++; $display("FAIL mid_reset: got %b want 111100", {csb0_1, csb1_1, csb0_3, csb1_3, busy1, busy3}); end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        vec++; if ({busy1, busy3, so1, so3} !== 4'b0011) begin errs++; $display("FAIL post_reset: got %b want 0011", {busy1, busy3, so1, so3}); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_trigger_during_scan();
        test_back_to_back();
        test_parity();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
